byte_block_packer: RTL and testbench
====================================

Name: byte_block_packer

Overview:
- Parametrised byte-to-block assembler for the I2C/Triple-DES datapath.
- Collects NUM_BYTES bytes from either the SRAM or the I2C byte stream and presents them as one BYTE_W*NUM_BYTES block to the DES core.
- Adds three things the first-generation packer lacked:
  - a consumer acknowledge, so the block is held until it is taken;
  - selectable byte order;
  - overrun detection.

Parameters:
- BYTE_W, 8: width of one input byte/word.
- NUM_BYTES, 8: bytes per output block; legal range 2..16.
- MSB_FIRST, 1: 1 = first byte received lands in the most-significant slot; 0 = first byte lands in the least-significant slot.

Ports:
- clk  input  1  system clock, all state on rising edge.
- nrst  input  1  asynchronous active-low reset.
- dir_sel  input  1  source select: 1 = from_sram, 0 = from_i2c.
- from_sram  input  BYTE_W  byte from SRAM path.
- from_i2c  input  BYTE_W  byte from I2C path.
- read_enable  input  1  selected byte is valid this cycle.
- clear  input  1  synchronous flush.
- block_ack  input  1  consumer takes the presented block.
- output_data  output  BYTE_W*NUM_BYTES  assembled block.
- data_ready  output  1  output_data holds a complete block.
- byte_count  output  $clog2(NUM_BYTES+1)  bytes accumulated in the current block.
- overrun  output  1  sticky: a byte was dropped while the block was full.

Behaviour:
- Reset (nrst low, asynchronous):
  - state = FILL; output_data = 0; byte_count = 0; data_ready = 0; overrun = 0.
- All outputs are registered. data_ready is high exactly when state = FULL.
- Byte mux: dir_sel is sampled only in cycles where read_enable = 1. It may change between bytes of the same block.
- Byte insertion:
  - MSB_FIRST = 1: output_data <= {output_data[upper NUM_BYTES-1 bytes], byte}, i.e. shift up by BYTE_W.
  - MSB_FIRST = 0: byte written into slot byte_count; bits [BYTE_W-1:0] hold the first byte.
- State FILL:
  - read_enable = 1 and byte_count < NUM_BYTES-1: insert byte; byte_count += 1.
  - read_enable = 1 and byte_count = NUM_BYTES-1: insert byte; byte_count = NUM_BYTES; go to FULL. data_ready rises the cycle after the last byte (1-cycle latency).
  - read_enable = 0: hold all state.
  - block_ack has no effect in FILL.
- State FULL:
  - output_data and byte_count (= NUM_BYTES) are held stable.
  - block_ack = 1, read_enable = 0: go to FILL; byte_count = 0. output_data is not cleared; stale bits are overwritten as new bytes arrive (MSB_FIRST = 0 overwrites slot-wise).
  - block_ack = 1, read_enable = 1 (same cycle): zero-bubble. Go to FILL; the new byte becomes byte 0 of the next block; byte_count = 1. The stale block is shifted/overwritten per the insertion rule.
  - block_ack = 0, read_enable = 1: byte dropped; output_data unchanged; overrun <= 1.
- overrun:
  - Sticky. Cleared only by clear or reset.
  - Never blocks operation.
- clear (synchronous, highest priority over all other inputs in the same cycle):
  - Next state = FILL; output_data = 0; byte_count = 0; overrun = 0. Any byte or ack in that cycle is ignored.
- Reset mid-block: partial data is discarded immediately; there is no recovery of partial blocks.
- byte_count never exceeds NUM_BYTES and never wraps.

Optional Feature:
- Macro PACKER_PARITY_EN.
- When defined:
  - Adds output port block_parity [NUM_BYTES-1:0]: even parity (XOR reduction) of each byte, computed on the selected input byte.
  - Registered into the bit position matching the byte's slot, following the same MSB_FIRST rule as output_data.
  - Reset and clear set it to 0. Held in FULL. Valid whenever data_ready = 1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, MSB_FIRST=1, dir_sel=0, from_i2c bytes 0x01..0x08 on 8 consecutive cycles -> data_ready rises the cycle after the 8th byte; output_data=0x0102030405060708; byte_count=8.
- MSB_FIRST=0, same stimulus -> output_data=0x0807060504030201.
- Block full, hold block_ack=0, pulse read_enable with 0xAA -> output_data unchanged; overrun=1 and stays 1; then clear -> overrun=0, byte_count=0, output_data=0.
- Block full, block_ack=1 and read_enable=1 with from_sram=0x55, dir_sel=1 in the same cycle -> next cycle data_ready=0, byte_count=1, least-significant byte of output_data=0x55 (MSB_FIRST=1).
- Alternate dir_sel per byte (sram 0xF0.., i2c 0x0F..) with read_enable gaps of 0-3 idle cycles -> block contains the correctly muxed bytes in order; count holds during gaps.
- Assert nrst low asynchronously after 5 bytes -> all outputs 0 immediately; 8 fresh bytes then produce a correct block. With PACKER_PARITY_EN, bytes 0x01,0x03 -> corresponding block_parity bits 1,0.

Source files
------------

// File: rtl/byte_block_packer.sv
// byte_block_packer
//   Collects NUM_BYTES bytes from the SRAM or I2C byte stream and presents
//   them as one BYTE_W*NUM_BYTES block to the DES core.
//   The block is held until block_ack. A byte arriving while the block is
//   full and unacknowledged is dropped and sets the sticky overrun flag.
//
// Ports
//   clk          system clock, all state on rising edge
//   nrst         asynchronous active-low reset
//   dir_sel      1 = take from_sram, 0 = take from_i2c (sampled with read_enable)
//   from_sram    byte from the SRAM path
//   from_i2c     byte from the I2C path
//   read_enable  selected byte is valid this cycle
//   clear        synchronous flush, highest priority
//   block_ack    consumer takes the presented block
//   output_data  assembled block
//   data_ready   output_data holds a complete block
//   byte_count   bytes accumulated in the current block
//   overrun      sticky: a byte was dropped while the block was full
//   block_parity (PACKER_PARITY_EN only) even parity of each byte, slot-aligned
//
// Optional feature macro: PACKER_PARITY_EN
module byte_block_packer #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              dir_sel,
    input  logic [BYTE_W-1:0]                 from_sram,
    input  logic [BYTE_W-1:0]                 from_i2c,
    input  logic                              read_enable,
    input  logic                              clear,
    input  logic                              block_ack,
    output logic [BYTE_W*NUM_BYTES-1:0]       output_data,
    output logic                              data_ready,
    output logic [$clog2(NUM_BYTES+1)-1:0]    byte_count,
    output logic                              overrun
`ifdef PACKER_PARITY_EN
    ,
    output logic [NUM_BYTES-1:0]              block_parity
`endif
);

    localparam int BLK_W = BYTE_W * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
    state_t state;

    logic [BYTE_W-1:0] sel_byte;
    assign sel_byte = dir_sel ? from_sram : from_i2c;

    // The state flop itself is the data_ready register.
    assign data_ready = (state == FULL);

    // MSB-first shifts the whole block up one byte; LSB-first writes the
    // byte into its slot so stale bytes above it survive until overwritten.
    function automatic logic [BLK_W-1:0] insert_byte(
        input logic [BLK_W-1:0]  blk,
        input logic [BYTE_W-1:0] b,
        input int                slot
    );
        logic [BLK_W-1:0] r;
        r = blk;
        if (MSB_FIRST != 0)
            r = {blk[BLK_W-BYTE_W-1:0], b};
        else
            r[slot*BYTE_W +: BYTE_W] = b;
        return r;
    endfunction

`ifdef PACKER_PARITY_EN
    function automatic logic [NUM_BYTES-1:0] insert_par(
        input logic [NUM_BYTES-1:0] par,
        input logic                 p,
        input int                   slot
    );
        logic [NUM_BYTES-1:0] r;
        r = par;
        if (MSB_FIRST != 0)
            r = {par[NUM_BYTES-2:0], p};
        else
            r[slot +: 1] = p;
        return r;
    endfunction
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= FILL;
            output_data <= '0;
            byte_count  <= '0;
            overrun     <= 1'b0;
`ifdef PACKER_PARITY_EN
            block_parity <= '0;
`endif
        end else if (clear) begin
            state       <= FILL;
            output_data <= '0;
            byte_count  <= '0;
            overrun     <= 1'b0;
`ifdef PACKER_PARITY_EN
            block_parity <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (read_enable) begin
                        output_data <= insert_byte(output_data, sel_byte, int'(byte_count));
`ifdef PACKER_PARITY_EN
                        block_parity <= insert_par(block_parity, ^sel_byte, int'(byte_count));
`endif
                        byte_count <= byte_count + CNT_W'(1);
                        if (byte_count == LAST_IDX)
                            state <= FULL;
                    end
                end
                FULL: begin
                    if (block_ack) begin
                        state <= FILL;
                        if (read_enable) begin
                            // Zero-bubble: this byte starts the next block in slot 0.
                            output_data <= insert_byte(output_data, sel_byte, 0);
`ifdef PACKER_PARITY_EN
                            block_parity <= insert_par(block_parity, ^sel_byte, 0);
`endif
                            byte_count <= CNT_W'(1);
                        end else begin
                            byte_count <= '0;
                        end
                    end else if (read_enable) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_block_packer.sv
module tb_byte_block_packer;

    localparam int BW = 8;
    localparam int NB = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        dir_sel;
    logic [7:0]  from_sram, from_i2c;
    logic        read_enable, clear, block_ack;

    logic [63:0] od1, od0;
    logic        rdy1, rdy0, ov1, ov0;
    logic [3:0]  cnt1, cnt0;
`ifdef PACKER_PARITY_EN
    logic [7:0]  par1, par0;
`endif

    always #5 clk = ~clk;

    byte_block_packer #(.BYTE_W(BW), .NUM_BYTES(NB), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .nrst(nrst), .dir_sel(dir_sel), .from_sram(from_sram),
        .from_i2c(from_i2c), .read_enable(read_enable), .clear(clear),
        .block_ack(block_ack), .output_data(od1), .data_ready(rdy1),
        .byte_count(cnt1), .overrun(ov1)
`ifdef PACKER_PARITY_EN
        , .block_parity(par1)
`endif
    );

    byte_block_packer #(.BYTE_W(BW), .NUM_BYTES(NB), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .nrst(nrst), .dir_sel(dir_sel), .from_sram(from_sram),
        .from_i2c(from_i2c), .read_enable(read_enable), .clear(clear),
        .block_ack(block_ack), .output_data(od0), .data_ready(rdy0),
        .byte_count(cnt0), .overrun(ov0)
`ifdef PACKER_PARITY_EN
        , .block_parity(par0)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model: bytes of the block in progress plus the block they overwrite.
    logic [7:0]  q[$];
    logic [63:0] base1, base0;
    logic [7:0]  pbase1, pbase0;
    bit          m_full, m_ovr;

    function automatic logic [63:0] exp_data(bit msb);
        logic [63:0] r;
        int n;
        n = q.size();
        if (msb) begin
            r = (n >= 8) ? 64'h0 : (base1 << (8 * n));
            for (int i = 0; i < n; i++) r = r | (64'(q[i]) << (8 * (n - 1 - i)));
        end else begin
            r = base0;
            for (int i = 0; i < n; i++) r[8*i +: 8] = q[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_par(bit msb);
        logic [7:0] r;
        int n;
        n = q.size();
        if (msb) begin
            r = (n >= 8) ? 8'h0 : (pbase1 << n);
            for (int i = 0; i < n; i++) r = r | (8'(^q[i]) << (n - 1 - i));
        end else begin
            r = pbase0;
            for (int i = 0; i < n; i++) r[i] = ^q[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        base1 = '0; base0 = '0; pbase1 = '0; pbase0 = '0;
        m_full = 0; m_ovr = 0;
    endtask

    task automatic model_edge();
        logic [7:0] b;
        b = dir_sel ? from_sram : from_i2c;
        if (clear) begin
            model_reset();
        end else if (!m_full) begin
            if (read_enable) begin
                q.push_back(b);
                if (q.size() == NB) m_full = 1;
            end
        end else if (block_ack) begin
            base1 = exp_data(1); base0 = exp_data(0);
            pbase1 = exp_par(1); pbase0 = exp_par(0);
            q.delete();
            m_full = 0;
            if (read_enable) q.push_back(b);
        end else if (read_enable) begin
            m_ovr = 1;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("data_msb", od1, exp_data(1));
        chk("data_lsb", od0, exp_data(0));
        chk("ready_msb", 64'(rdy1), 64'(m_full));
        chk("ready_lsb", 64'(rdy0), 64'(m_full));
        chk("count_msb", 64'(cnt1), 64'(q.size()));
        chk("count_lsb", 64'(cnt0), 64'(q.size()));
        chk("ovr_msb", 64'(ov1), 64'(m_ovr));
        chk("ovr_lsb", 64'(ov0), 64'(m_ovr));
`ifdef PACKER_PARITY_EN
        chk("par_msb", 64'(par1), 64'(exp_par(1)));
        chk("par_lsb", 64'(par0), 64'(exp_par(0)));
`endif
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        read_enable = 0; block_ack = 0; clear = 0;
    endtask

    task automatic send_i2c(logic [7:0] b);
        dir_sel = 0; from_i2c = b; from_sram = ~b; read_enable = 1;
        step();
        read_enable = 0;
    endtask

    initial begin
        logic [7:0] fresh [8];
        fresh = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        nrst = 0; dir_sel = 0; from_sram = 0; from_i2c = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_data", od1, 64'h0);
        chk("rst_ready", 64'(rdy1), 64'h0);
        chk("rst_count", 64'(cnt0), 64'h0);
        chk("rst_ovr", 64'(ov1), 64'h0);
        nrst = 1;

        // Basic fill, both byte orders
        for (int i = 1; i <= 8; i++) send_i2c(8'(i));
        chk("blk1_msb", od1, 64'h0102030405060708);
        chk("blk1_lsb", od0, 64'h0807060504030201);
        chk("blk1_ready", 64'(rdy1), 64'h1);
        chk("blk1_count", 64'(cnt1), 64'd8);

        // Overrun while held
        send_i2c(8'hAA);
        step(); step();
        chk("ovr_set", 64'(ov1), 64'h1);
        chk("ovr_hold_data", od1, 64'h0102030405060708);
        clear = 1; block_ack = 1; dir_sel = 0; from_i2c = 8'h99; read_enable = 1;
        step();
        idle_inputs();
        chk("clr_ovr", 64'(ov0), 64'h0);
        chk("clr_count", 64'(cnt1), 64'h0);
        chk("clr_data", od1, 64'h0);
        step();

        // Zero-bubble ack + byte
        for (int i = 1; i <= 8; i++) send_i2c(8'(i));
        block_ack = 1; read_enable = 1; dir_sel = 1; from_sram = 8'h55; from_i2c = 8'h33;
        step();
        idle_inputs();
        chk("zb_ready", 64'(rdy1), 64'h0);
        chk("zb_count", 64'(cnt1), 64'd1);
        chk("zb_lsbyte_msb", 64'(od1[7:0]), 64'h55);
        chk("zb_lsbyte_lsb", 64'(od0[7:0]), 64'h55);

        // Alternating sources with idle gaps
        for (int k = 1; k <= 7; k++) begin
            repeat (k % 4) step();
            dir_sel = 1'(k % 2);
            from_sram = 8'hF0 | 8'(k);
            from_i2c = 8'h0F | 8'(k << 4);
            if (dir_sel) from_i2c = ~from_sram; else from_sram = ~from_i2c;
            read_enable = 1;
            step();
            read_enable = 0;
        end
        chk("mux_msb", od1, 64'h55F12FF34FF56FF7);
        chk("mux_lsb", od0, 64'hF76FF54FF32FF155);

        // Plain ack: stale data retained, count back to 0
        block_ack = 1;
        step();
        idle_inputs();
        chk("ack_count", 64'(cnt1), 64'h0);
        chk("ack_stale", od1, 64'h55F12FF34FF56FF7);

        // Asynchronous reset mid-block
        for (int i = 0; i < 5; i++) send_i2c(fresh[i]);
        #2 nrst = 0;
        #1;
        chk("arst_data", od1, 64'h0);
        chk("arst_count", 64'(cnt1), 64'h0);
        chk("arst_ovr_ready", {62'h0, ov1, rdy1}, 64'h0);
        model_reset();
        @(negedge clk);
        nrst = 1;
        for (int i = 0; i < 8; i++) send_i2c(fresh[i]);
        chk("fresh_msb", od1, 64'h0103070F1F3F7FFF);
        chk("fresh_ready", 64'(rdy0), 64'h1);
`ifdef PACKER_PARITY_EN
        chk("fresh_par_msb", 64'(par1), 64'hAA);
        chk("fresh_par_lsb", 64'(par0), 64'h55);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
